// File: rtl/ixc_bp_pkg.sv
// Shared types and helpers for the breakpoint-wait controller.
package ixc_bp_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETTLE  = 3'd1,
      REQ     = 3'd2,
      RELEASE = 3'd3,
      REARM   = 3'd4
   } bp_state_e;

   // Width of a counter that must reach holdCyc.
   function automatic int unsigned holdCntW(input int unsigned holdCyc);
      return $clog2(holdCyc + 1);
   endfunction

endpackage

// File: rtl/ixc_bp_snap_reg.sv
// Source snapshot register: load on breakpoint entry, OR-accumulate while settling, hold otherwise.
module ixc_bp_snap_reg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         acc,
   input  logic [W-1:0] din,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       q <= '0;
      else if (load) q <= din;
      else if (acc)  q <= q | din;
   end

endmodule

// File: rtl/ixc_bp_wait_ctrl.sv
// Breakpoint-wait controller: freezes detector latches on a drOn change, settles,
// handshakes with the host and releases only after the acknowledge.
module ixc_bp_wait_ctrl
   import ixc_bp_pkg::*;
#(
   parameter int unsigned NUM_SRC  = 8,
   parameter int unsigned HOLD_CYC = 2,
   parameter int unsigned CNT_W    = 16
) (
   input  logic               fclk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] dr_on,
   input  logic               bp_enable,
   output logic               bp_wait,
   output logic               host_req,
   input  logic               host_ack,
   output logic [NUM_SRC-1:0] src_snapshot,
   output logic [CNT_W-1:0]   bp_count
);

   localparam int unsigned HOLD_W = holdCntW(HOLD_CYC);

   bp_state_e         state, stateNext;
   logic [HOLD_W-1:0] holdCnt, holdCntNext;
   logic [CNT_W-1:0]  countNext;
   logic              bpWaitNext, hostReqNext;
   logic              snapLoad, snapAcc;

   // Next-state, hold counter, event counter and registered-output decode.
   always_comb begin
      stateNext   = state;
      holdCntNext = holdCnt;
      countNext   = bp_count;
      snapLoad    = 1'b0;
      snapAcc     = 1'b0;
      case (state)
         IDLE: begin
            if (bp_enable && (|dr_on)) begin
               stateNext   = SETTLE;
               holdCntNext = '0;
               snapLoad    = 1'b1;
               if (bp_count != '1) countNext = bp_count + CNT_W'(1);
            end
         end
         SETTLE: begin
            snapAcc = 1'b1;
            if (holdCnt == HOLD_W'(HOLD_CYC - 1)) begin
               stateNext   = REQ;
               holdCntNext = '0;
            end else begin
               holdCntNext = holdCnt + HOLD_W'(1);
            end
         end
         REQ:     if (host_ack) stateNext = RELEASE;
         RELEASE: stateNext = REARM;
         // Wait for the host to drop its ack so one ack cannot span two breakpoints.
         REARM:   if (!host_ack) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
      bpWaitNext  = (stateNext == SETTLE) || (stateNext == REQ);
      hostReqNext = (stateNext == REQ);
   end

   always_ff @(posedge fclk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         holdCnt  <= '0;
         bp_count <= '0;
         bp_wait  <= 1'b0;
         host_req <= 1'b0;
      end else begin
         state    <= stateNext;
         holdCnt  <= holdCntNext;
         bp_count <= countNext;
         bp_wait  <= bpWaitNext;
         host_req <= hostReqNext;
      end
   end

   ixc_bp_snap_reg #(.W(NUM_SRC)) u_snap (
      .clk  (fclk),
      .rst  (rst),
      .load (snapLoad),
      .acc  (snapAcc),
      .din  (dr_on),
      .q    (src_snapshot)
   );

endmodule
